// File: rtl/olf_pkg.sv
// Shared types for the orientation-lookup datapath: distance type, its
// saturating maximum, and the argmin frame-tracker state encoding.
package olf_pkg;
  typedef logic [15:0] dist_t;

  localparam dist_t DIST_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } argmin_state_e;
endpackage

// File: rtl/angledist_argmin.sv
// Frame-wise argmin over streamed angle distances with a 1-deep result register.
// Optional second-best margin output enabled by ANGLEDIST_ARGMIN_SECOND_BEST_EN.
module angledist_argmin
  import olf_pkg::*;
#(
  parameter  int NUM_CLASSES = 16,
  localparam int IDW         = $clog2(NUM_CLASSES)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           dist_valid_i,
  input  logic [15:0]    dist_i,
  input  logic [IDW-1:0] class_id_i,
  input  logic           last_i,
  output logic           result_valid_o,
  input  logic           result_ready_i,
  output logic [IDW-1:0] best_id_o,
  output logic [15:0]    best_dist_o,
  output logic           overflow_o
`ifdef ANGLEDIST_ARGMIN_SECOND_BEST_EN
  ,
  output logic [15:0]    margin_o
`endif
);

  localparam int            CW      = $clog2(NUM_CLASSES + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(NUM_CLASSES);

  argmin_state_e  r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  dist_t          r_min, w_min_nxt;
  logic [IDW-1:0] r_min_id, w_min_id_nxt;

  logic           r_res_valid;
  logic [IDW-1:0] r_res_id;
  dist_t          r_res_dist;
  logic           r_ovf;

  logic w_take, w_first, w_lt, w_last, w_done, w_hs;

  assign w_take  = dist_valid_i && !clear_i;
  assign w_first = (r_state == ST_IDLE);
  assign w_lt    = (dist_i < r_min);
  // A full frame's worth of samples already seen forces this one to close it.
  assign w_last  = last_i || (r_cnt == CNT_LIM);
  assign w_done  = w_take && w_last;
  assign w_hs    = r_res_valid && result_ready_i;

`ifdef ANGLEDIST_ARGMIN_SECOND_BEST_EN
  dist_t r_sec, w_sec_nxt;
  dist_t r_res_margin;
  dist_t w_margin;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_min    <= DIST_MAX;
      r_min_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_min    <= w_min_nxt;
      r_min_id <= w_min_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_min_nxt    = r_min;
    w_min_id_nxt = r_min_id;
    if (clear_i) begin
      w_state_nxt  = ST_IDLE;
      w_cnt_nxt    = '0;
      w_min_nxt    = DIST_MAX;
      w_min_id_nxt = '0;
    end else if (dist_valid_i) begin
      // First sample loads unconditionally so an all-FFFF frame still reports an id.
      if (w_first || w_lt) begin
        w_min_nxt    = dist_i;
        w_min_id_nxt = class_id_i;
      end
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ST_ACCUM;
        w_cnt_nxt   = r_cnt + CW'(1);
      end
    end
  end

`ifdef ANGLEDIST_ARGMIN_SECOND_BEST_EN
  // DIST_MAX doubles as the "no second sample" sentinel; ties land in r_sec.
  always_comb begin
    w_sec_nxt = r_sec;
    if (clear_i) begin
      w_sec_nxt = DIST_MAX;
    end else if (dist_valid_i) begin
      if (w_first)                w_sec_nxt = DIST_MAX;
      else if (w_lt)              w_sec_nxt = r_min;
      else if (dist_i < r_sec)    w_sec_nxt = dist_i;
    end
  end

  assign w_margin = w_first ? DIST_MAX : dist_t'(w_sec_nxt - w_min_nxt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sec        <= DIST_MAX;
      r_res_margin <= DIST_MAX;
    end else begin
      r_sec <= w_sec_nxt;
      if (w_done && (!r_res_valid || w_hs)) r_res_margin <= w_margin;
    end
  end

  assign margin_o = r_res_margin;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_dist  <= DIST_MAX;
      r_ovf       <= 1'b0;
    end else if (w_done && (!r_res_valid || w_hs)) begin
      r_res_valid <= 1'b1;
      r_res_id    <= w_min_id_nxt;
      r_res_dist  <= w_min_nxt;
    end else if (w_done) begin
      r_ovf <= 1'b1;
    end else if (w_hs) begin
      r_res_valid <= 1'b0;
    end
  end

  assign result_valid_o = r_res_valid;
  assign best_id_o      = r_res_id;
  assign best_dist_o    = r_res_dist;
  assign overflow_o     = r_ovf;

endmodule

// File: tb/tb_angledist_argmin.sv
// Randomised + directed bench for angledist_argmin against a queue-based frame model.
module tb_angledist_argmin;
  localparam int N   = 8;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_i = 1'b1, clear_i = 1'b0, dist_valid_i = 1'b0, last_i = 1'b0;
  logic           result_ready_i = 1'b0;
  logic [15:0]    dist_i = '0;
  logic [IDW-1:0] class_id_i = '0;
  logic           result_valid_o, overflow_o;
  logic [IDW-1:0] best_id_o;
  logic [15:0]    best_dist_o;
`ifdef ANGLEDIST_ARGMIN_SECOND_BEST_EN
  logic [15:0]    margin_o;
`endif

  int n_chk = 0, n_pass = 0;

  angledist_argmin #(.NUM_CLASSES(N)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .dist_valid_i(dist_valid_i),
    .dist_i(dist_i), .class_id_i(class_id_i), .last_i(last_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .best_id_o(best_id_o), .best_dist_o(best_dist_o), .overflow_o(overflow_o)
`ifdef ANGLEDIST_ARGMIN_SECOND_BEST_EN
    , .margin_o(margin_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: collect the frame, then pick the earliest minimum by scanning it.
  int q_d[$], q_id[$];
  bit m_valid, m_ovf, started;
  int m_id, m_dist, m_margin;

  always @(posedge clk) begin
    bit done;
    int bi, sec, nm;
    done = 0; bi = 0; sec = 0; nm = 0;
    if (rst_i) begin
      q_d.delete(); q_id.delete();
      m_valid = 0; m_ovf = 0; m_id = 0; m_dist = 65535; m_margin = 65535;
      started = 1;
    end else begin
      if (clear_i) begin
        q_d.delete(); q_id.delete();
      end else if (dist_valid_i) begin
        q_d.push_back(int'(dist_i)); q_id.push_back(int'(class_id_i));
        if (last_i || q_d.size() == N + 1) begin
          done = 1;
          for (int i = 1; i < q_d.size(); i++) if (q_d[i] < q_d[bi]) bi = i;
          sec = 65535;
          for (int i = 0; i < q_d.size(); i++) if (i != bi && q_d[i] < sec) sec = q_d[i];
          nm = (q_d.size() == 1) ? 65535 : sec - q_d[bi];
        end
      end
      if (done && (!m_valid || result_ready_i)) begin
        m_valid = 1; m_id = q_id[bi]; m_dist = q_d[bi]; m_margin = nm;
      end else if (done) begin
        m_ovf = 1;
      end else if (m_valid && result_ready_i) begin
        m_valid = 0;
      end
      if (done) begin q_d.delete(); q_id.delete(); end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_valid", result_valid_o, m_valid);
      check("cyc_id",    best_id_o,      m_id);
      check("cyc_dist",  best_dist_o,    m_dist);
      check("cyc_ovf",   overflow_o,     m_ovf);
`ifdef ANGLEDIST_ARGMIN_SECOND_BEST_EN
      check("cyc_margin", margin_o, m_margin);
`endif
    end
  end

  task automatic sample(input int d, input int id, input logic l, input logic clr = 1'b0);
    dist_valid_i = 1'b1; dist_i = 16'(d); class_id_i = IDW'(id); last_i = l; clear_i = clr;
    @(posedge clk); #1;
    dist_valid_i = 1'b0; last_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", result_valid_o, 0);
    check("rst_id",    best_id_o,      0);
    check("rst_dist",  best_dist_o,    16'hFFFF);
    check("rst_ovf",   overflow_o,     0);
    rst_i = 1'b0;

    // {300,120,120,500}: tie keeps earliest
    result_ready_i = 1'b1;
    sample(300, 0, 0); sample(120, 1, 0); sample(120, 2, 0); sample(500, 3, 1);
    check("f1_valid", result_valid_o, 1);
    check("f1_id",    best_id_o,      1);
    check("f1_dist",  best_dist_o,    120);
`ifdef ANGLEDIST_ARGMIN_SECOND_BEST_EN
    check("f1_margin", margin_o, 0);
`endif
    idle(1);
    check("f1_drop", result_valid_o, 0);

    sample(16'hFFFF, 5, 1);
    check("single_id",   best_id_o,   5);
    check("single_dist", best_dist_o, 16'hFFFF);
`ifdef ANGLEDIST_ARGMIN_SECOND_BEST_EN
    check("single_margin", margin_o, 16'hFFFF);
`endif
    idle(1);

    // clear wins over a same-cycle sample, even one flagged last
    sample(7, 0, 0); sample(8, 1, 0); sample(1, 5, 1, 1'b1);
    check("clr_novalid", result_valid_o, 0);
    sample(40, 2, 0); sample(90, 3, 1);
    check("clr_id",   best_id_o,   2);
    check("clr_dist", best_dist_o, 40);
    idle(1);

    result_ready_i = 1'b0;
    sample(20, 0, 0); sample(10, 1, 1); sample(7, 2, 0); sample(30, 3, 1);
    check("ovf_dist",  best_dist_o,    10);
    check("ovf_id",    best_id_o,      1);
    check("ovf_valid", result_valid_o, 1);
    check("ovf_flag",  overflow_o,     1);
    result_ready_i = 1'b1;
    idle(1);
    check("ovf_consumed", result_valid_o, 0);
    check("ovf_sticky",   overflow_o,     1);

    sample(3, 1, 0);
    rst_i = 1'b1; idle(1); rst_i = 1'b0;
    check("rst2_ovf", overflow_o, 0);
    sample(50, 2, 1);
    check("rst2_dist", best_dist_o, 50);
    check("rst2_id",   best_id_o,   2);
    idle(1);

    result_ready_i = 1'b0;
    sample(60, 1, 1);
    check("hs_first", best_dist_o, 60);
    result_ready_i = 1'b1;
    sample(25, 4, 1);
    check("hs_valid", result_valid_o, 1);
    check("hs_id",    best_id_o,      4);
    check("hs_dist",  best_dist_o,    25);
    check("hs_ovf",   overflow_o,     0);
    idle(1);

    for (int i = 0; i < N; i++) sample(100 - 5 * i, i % N, 0);
    check("force_early", result_valid_o, 0);
    sample(100 - 5 * N, N % N, 0);
    check("force_valid", result_valid_o, 1);
    check("force_dist",  best_dist_o,    60);
    check("force_id",    best_id_o,      0);
    sample(200, 3, 1);
    check("force_new_dist", best_dist_o, 200);
    check("force_new_id",   best_id_o,   3);

    for (int k = 0; k < 3000; k++) begin
      rst_i          = ($urandom_range(0, 199) == 0);
      clear_i        = ($urandom_range(0, 39) == 0);
      dist_valid_i   = ($urandom_range(0, 3) != 0);
      last_i         = ($urandom_range(0, 5) == 0);
      result_ready_i = ($urandom_range(0, 2) != 0);
      dist_i         = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
      class_id_i     = IDW'($urandom_range(0, N - 1));
      @(posedge clk); #1;
    end
    rst_i = 1'b0; clear_i = 1'b0; dist_valid_i = 1'b0; last_i = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
